// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared store-size and drain-FSM encodings for the MEM-stage
//               store path.
// Revision    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_if
// Description : MEM-stage store port plus data-memory write port of the
//               store buffer.
// Revision    : 1.0  initial release
// ============================================================================
interface store_buffer_if #(
    parameter int CNT_W = 3
);
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_size;
    logic             misalign;
    logic             mem_req;
    logic             mem_ack;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             empty;
    logic [CNT_W-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, misalign, mem_req, mem_addr, mem_wdata, mem_be,
               empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, misalign, mem_req, mem_addr, mem_wdata, mem_be,
               empty, count
    );
endinterface
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_align
// Description : Little-endian lane replication and byte-enable generation for
//               SB/SH/SW, with misalignment / reserved-size detection.
// Revision    : 1.0  initial release
// ============================================================================
module store_lane_align
    import mips_mem_pkg::*;
(
    input  wire logic [1:0]  st_addr,
    input  wire logic [1:0]  st_size,
    input  wire logic [31:0] st_data,
    output logic      [31:0] wdata,
    output logic      [3:0]  be,
    output logic             bad
);

    always_comb begin
        wdata = '0;
        be    = '0;
        bad   = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                wdata = {4{st_data[7:0]}};
                be    = 4'b0001 << st_addr;
            end
            SZ_HALF: begin
                wdata = {2{st_data[15:0]}};
                be    = st_addr[1] ? 4'b1100 : 4'b0011;
                bad   = st_addr[0];
            end
            SZ_WORD: begin
                wdata = st_data;
                be    = 4'b1111;
                bad   = (st_addr != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Aligns MEM-stage stores, queues them in a small FIFO and
//               drains them to data memory over a req/ack handshake.
// Revision    : 1.0  initial release
// ============================================================================
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    store_buffer_if.slave  sb
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    sb_entry_t        fifo_q [DEPTH];
    sb_entry_t        fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    drain_state_e     state_q, state_d;
    sb_entry_t        out_q, out_d;

    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_bad;
    logic        w_ready;
    logic        w_take;
    logic        w_push;
    logic        w_pop;

    store_lane_align u_align (
        .st_addr (sb.st_addr[1:0]),
        .st_size (sb.st_size),
        .st_data (sb.st_data),
        .wdata   (w_wdata),
        .be      (w_be),
        .bad     (w_bad)
    );

    // Full blocks pushes even if the head retires this cycle.
    assign w_ready = (count_q != C_FULL);
    assign w_take  = sb.st_valid & w_ready;
    assign w_push  = w_take & ~w_bad;
    assign w_pop   = (state_q == ST_REQ) & sb.mem_ack;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = w_take & w_bad;
        if (w_push) begin
            fifo_d[wr_ptr_q] = '{word_addr: sb.st_addr[31:2], wdata: w_wdata, be: w_be};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Looking at the post-push count lets a store into an empty buffer
    // reach memory on the very next cycle.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: if (count_d != '0) state_d = ST_REQ;
            ST_REQ:  if (w_pop && count_d == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_REQ && (state_q == ST_IDLE || w_pop)) begin
            out_d = fifo_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            state_q    <= ST_IDLE;
            out_q      <= '0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            state_q    <= state_d;
            out_q      <= out_d;
        end
    end

    assign sb.st_ready  = w_ready;
    assign sb.misalign  = misalign_q;
    assign sb.mem_req   = (state_q == ST_REQ);
    assign sb.mem_addr  = {out_q.word_addr, 2'b00};
    assign sb.mem_wdata = out_q.wdata;
    assign sb.mem_be    = out_q.be;
    assign sb.empty     = (count_q == '0);
    assign sb.count     = count_q;

endmodule
`default_nettype wire
